// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / load-store) arbiter in front of a single memory port.
// Round-robin grant, one transaction in flight, all outputs registered.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_done,
    output logic [DATA_WIDTH-1:0]   i_rdata,

    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wmask,
    output logic                    d_done,
    output logic [DATA_WIDTH-1:0]   d_rdata,

    output logic                    load,
    output logic                    store,
    output logic [ADDR_WIDTH-1:0]   memory_access_address,
    output logic [DATA_WIDTH-1:0]   memory_write_data,
    output logic [DATA_WIDTH/8-1:0] memory_write_mask,
    input  logic                    memory_read_busy,
    input  logic                    memory_write_busy,
    input  logic [DATA_WIDTH-1:0]   memory_read_data
);

    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic {GNT_FETCH, GNT_DATA} grant_t;

    state_t                  state_q, state_d;
    grant_t                  last_q, last_d;
    logic                    we_q, we_d;
    logic                    load_q, load_d;
    logic                    store_q, store_d;
    logic                    i_done_q, i_done_d;
    logic                    d_done_q, d_done_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [MASK_WIDTH-1:0]   wmask_q, wmask_d;
    logic [DATA_WIDTH-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;

    // Data side wins when it is alone, or on a tie when fetch was served last.
    logic                    pick_data;
    logic                    win_we;
    logic [MASK_WIDTH-1:0]   win_wmask;
    logic                    finish;
    logic                    busy;

    assign pick_data = d_req && (!i_req || (last_q == GNT_FETCH));
    assign win_we    = pick_data ? d_we : 1'b0;
    assign win_wmask = pick_data ? d_wmask : '0;
    assign busy      = we_q ? memory_write_busy : memory_read_busy;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        load_d    = 1'b0;
        store_d   = 1'b0;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        finish    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    addr_d  = pick_data ? d_addr : i_addr;
                    wdata_d = pick_data ? d_wdata : '0;
                    wmask_d = win_wmask;
                    we_d    = win_we;
                    last_d  = pick_data ? GNT_DATA : GNT_FETCH;
                    load_d  = !win_we;
                    store_d = win_we && (win_wmask != '0);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // An empty byte mask writes nothing, so memory is never touched.
                if (we_q && (wmask_q == '0)) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!busy) begin
                    finish  = 1'b1;
                    state_d = DONE;
                    if (!we_q) begin
                        if (last_q == GNT_DATA) d_rdata_d = memory_read_data;
                        else                    i_rdata_d = memory_read_data;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (finish) begin
            if (last_q == GNT_DATA) d_done_d = 1'b1;
            else                    i_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= GNT_DATA;
            we_q      <= 1'b0;
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            we_q      <= we_d;
            load_q    <= load_d;
            store_q   <= store_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign load                  = load_q;
    assign store                 = store_q;
    assign i_done                = i_done_q;
    assign d_done                = d_done_q;
    assign i_rdata               = i_rdata_q;
    assign d_rdata               = d_rdata_q;
    assign memory_access_address = addr_q;
    assign memory_write_data     = wdata_q;
    assign memory_write_mask     = wmask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (round-robin rule, byte-addressed reference memory).
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [MW-1:0] d_wmask = '0;
    logic          i_done, d_done, load, store;
    logic [DW-1:0] i_rdata, d_rdata, memory_write_data;
    logic [DW-1:0] memory_read_data = '0;
    logic [AW-1:0] memory_access_address;
    logic [MW-1:0] memory_write_mask;
    logic          memory_read_busy = 1'b0, memory_write_busy = 1'b0;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wmask(d_wmask), .d_done(d_done), .d_rdata(d_rdata),
        .load(load), .store(store),
        .memory_access_address(memory_access_address),
        .memory_write_data(memory_write_data),
        .memory_write_mask(memory_write_mask),
        .memory_read_busy(memory_read_busy),
        .memory_write_busy(memory_write_busy),
        .memory_read_data(memory_read_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int lat = 0;

    // Environment memory (seen by the responder) and the model's own copy.
    logic [DW-1:0] env_mem[logic [AW-1:0]];
    logic [DW-1:0] ref_mem[logic [AW-1:0]];
    bit            ref_last_d = 1'b1;

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < MW; b++) if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    // Round-robin rule: a lone requester wins; on a tie the one not served last wins.
    function automatic bit pick(input bit ir, input bit dr);
        if (ir && dr) return !ref_last_d;
        return dr;
    endfunction

    // Memory responder: relevant busy stays high for 'lat' cycles after the strobe;
    // the other busy line toggles randomly and must be ignored by the arbiter.
    int rcnt = 0;
    bit is_rd = 1'b1;
    always @(negedge clk) begin
        if (reset) begin
            rcnt = 0;
            memory_read_busy = 1'b0;
            memory_write_busy = 1'b0;
        end else if (load) begin
            is_rd = 1'b1;
            rcnt = lat;
            memory_read_data = env_mem.exists(memory_access_address) ?
                               env_mem[memory_access_address] : dflt(memory_access_address);
            memory_read_busy = (lat > 0);
            memory_write_busy = 1'($urandom_range(0, 1));
        end else if (store) begin
            is_rd = 1'b0;
            rcnt = lat;
            env_mem[memory_access_address] = merge(env_mem.exists(memory_access_address) ?
                env_mem[memory_access_address] : dflt(memory_access_address),
                memory_write_data, memory_write_mask);
            memory_write_busy = (lat > 0);
            memory_read_busy = 1'($urandom_range(0, 1));
        end else begin
            if (is_rd) begin
                memory_read_busy = (rcnt > 0);
                memory_write_busy = 1'($urandom_range(0, 1));
            end else begin
                memory_write_busy = (rcnt > 0);
                memory_read_busy = 1'($urandom_range(0, 1));
            end
            if (rcnt > 0) rcnt = rcnt - 1;
        end
    end

    // Observations of the last transaction (filled by run_txn, judged by the tests).
    int            obs_k, obs_nld, obs_nst;
    bit            obs_side, obs_unst, obs_extra;
    logic [DW-1:0] obs_rdata, obs_wdata;
    logic [AW-1:0] obs_addr;
    logic [MW-1:0] obs_mask;

    // Called at a negedge while the arbiter is idle with requests set up. Counts
    // cycles until a done pulse, then steps into the following idle cycle and
    // drops the served request.
    task automatic run_txn();
        obs_k = -1; obs_nld = 0; obs_nst = 0; obs_side = 0; obs_unst = 0; obs_extra = 0;
        obs_rdata = '0; obs_wdata = '0; obs_addr = '0; obs_mask = '0;
        for (int k = 1; k <= 40 && obs_k < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                obs_addr = memory_access_address;
                obs_wdata = memory_write_data;
                obs_mask = memory_write_mask;
            end else if (memory_access_address !== obs_addr || memory_write_data !== obs_wdata ||
                         memory_write_mask !== obs_mask) begin
                obs_unst = 1;
            end
            obs_nld += int'(load);
            obs_nst += int'(store);
            if (i_done || d_done) begin
                obs_k = k;
                obs_side = d_done;
                obs_extra = i_done && d_done;
                obs_rdata = d_done ? d_rdata : i_rdata;
            end
        end
        if (obs_k > 0) begin
            @(negedge clk);
            if (i_done || d_done || load || store) obs_extra = 1;
            if (obs_side) d_req = 1'b0; else i_req = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ref_last_d = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; i_req = 1'b1; d_req = 1'b1; i_addr = 32'hFFFF_FFF0;
        repeat (2) @(negedge clk);
        checks++;
        if ({load, store, i_done, d_done} !== 4'b0) begin
            errors++; $display("FAIL reset_strobes: got %b expected 0000", {load, store, i_done, d_done});
        end
        checks++;
        if (memory_access_address !== '0 || memory_write_data !== '0 || memory_write_mask !== '0) begin
            errors++; $display("FAIL reset_mem_regs: got addr %h data %h mask %h expected zero",
                               memory_access_address, memory_write_data, memory_write_mask);
        end
        checks++;
        if (i_rdata !== '0 || d_rdata !== '0) begin
            errors++; $display("FAIL reset_rdata: got %h/%h expected 0", i_rdata, d_rdata);
        end
        i_req = 1'b0; d_req = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_fetch_only();
        apply_reset();
        env_mem[32'h100] = 32'hDEADBEEF; ref_mem[32'h100] = 32'hDEADBEEF;
        lat = 2; i_addr = 32'h100; i_req = 1'b1;
        run_txn();
        checks++;
        if (obs_k !== 5 || obs_side !== 1'b0) begin
            errors++; $display("FAIL fetch_done: got k=%0d side=%0d expected k=5 side=0", obs_k, obs_side);
        end
        checks++;
        if (obs_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL fetch_rdata: got %h expected deadbeef", obs_rdata);
        end
        checks++;
        if (obs_nld !== 1 || obs_nst !== 0 || obs_addr !== 32'h100 || obs_mask !== '0) begin
            errors++; $display("FAIL fetch_strobe: got loads=%0d stores=%0d addr=%h mask=%b expected 1 0 100 0000",
                               obs_nld, obs_nst, obs_addr, obs_mask);
        end
        checks++;
        if (obs_extra !== 1'b0 || obs_unst !== 1'b0) begin
            errors++; $display("FAIL fetch_clean: got extra=%0d unstable=%0d expected 0 0", obs_extra, obs_unst);
        end
    endtask

    task automatic test_store();
        apply_reset();
        lat = 1; d_we = 1'b1; d_addr = 32'h204; d_wdata = 32'h0000_00AB; d_wmask = 4'b0001; d_req = 1'b1;
        run_txn();
        ref_mem[32'h204] = merge(ref_read(32'h204), 32'hAB, 4'b0001);
        checks++;
        if (obs_k !== 4 || obs_side !== 1'b1) begin
            errors++; $display("FAIL store_done: got k=%0d side=%0d expected k=4 side=1", obs_k, obs_side);
        end
        checks++;
        if (obs_nst !== 1 || obs_nld !== 0) begin
            errors++; $display("FAIL store_strobes: got stores=%0d loads=%0d expected 1 0", obs_nst, obs_nld);
        end
        checks++;
        if (obs_addr !== 32'h204 || obs_wdata !== 32'hAB || obs_mask !== 4'b0001) begin
            errors++; $display("FAIL store_fields: got %h %h %b expected 204 000000ab 0001",
                               obs_addr, obs_wdata, obs_mask);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        lat = 1; d_we = 1'b0;
        i_addr = 32'h300; d_addr = 32'h304; i_req = 1'b1; d_req = 1'b1;
        for (int t = 0; t < 4; t++) begin
            run_txn();
            checks++;
            if (obs_side !== 1'(t % 2) || obs_k !== 4) begin
                errors++; $display("FAIL contention_order_%0d: got side=%0d k=%0d expected side=%0d k=4",
                                   t, obs_side, obs_k, t % 2);
            end
            checks++;
            if (obs_extra !== 1'b0) begin
                errors++; $display("FAIL contention_pulse_%0d: got extra=%0d expected 0", t, obs_extra);
            end
            if (obs_side) begin d_addr = d_addr + 8; d_req = 1'b1; end
            else          begin i_addr = i_addr + 8; i_req = 1'b1; end
        end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_zero_mask();
        apply_reset();
        lat = 3; d_we = 1'b1; d_addr = 32'h208; d_wdata = 32'h5555_5555; d_wmask = '0; d_req = 1'b1;
        run_txn();
        checks++;
        if (obs_k !== 2 || obs_side !== 1'b1) begin
            errors++; $display("FAIL zero_mask_done: got k=%0d side=%0d expected k=2 side=1", obs_k, obs_side);
        end
        checks++;
        if (obs_nst !== 0 || obs_nld !== 0) begin
            errors++; $display("FAIL zero_mask_strobe: got stores=%0d loads=%0d expected 0 0", obs_nst, obs_nld);
        end
    endtask

    task automatic test_reset_in_wait();
        bit saw_done;
        apply_reset();
        lat = 10; i_addr = 32'h80; i_req = 1'b1;
        saw_done = 0;
        repeat (3) begin @(negedge clk); if (i_done || d_done) saw_done = 1; end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({load, store, i_done, d_done} !== 4'b0 || memory_access_address !== '0) begin
            errors++; $display("FAIL rst_wait_outputs: got strobes=%b addr=%h expected 0",
                               {load, store, i_done, d_done}, memory_access_address);
        end
        i_req = 1'b0; reset = 1'b0; ref_last_d = 1'b1;
        repeat (4) begin @(negedge clk); if (i_done || d_done || load || store) saw_done = 1; end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++; $display("FAIL rst_wait_no_done: got activity=%0d expected 0", saw_done);
        end
        lat = 0; d_we = 1'b0; i_addr = 32'h84; d_addr = 32'h88; i_req = 1'b1; d_req = 1'b1;
        run_txn();
        checks++;
        if (obs_side !== 1'b0 || obs_k !== 3) begin
            errors++; $display("FAIL rst_wait_grant: got side=%0d k=%0d expected side=0 k=3", obs_side, obs_k);
        end
        d_req = 1'b0;
    endtask

    task automatic test_min_latency();
        apply_reset();
        lat = 0; i_addr = 32'h10; i_req = 1'b1;
        run_txn();
        checks++;
        if (obs_k !== 3 || obs_rdata !== ref_read(32'h10)) begin
            errors++; $display("FAIL min_latency: got k=%0d rdata=%h expected k=3 rdata=%h",
                               obs_k, obs_rdata, ref_read(32'h10));
        end
    endtask

    task automatic test_random();
        bit            exp_d, zm, rd;
        int            exp_k;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew;
        logic [MW-1:0] em;
        apply_reset();
        for (int n = 0; n < 80; n++) begin
            if (!i_req && $urandom_range(0, 99) < 60) begin
                i_req = 1'b1; i_addr = 32'h400 + 32'($urandom_range(0, 7)) * 4;
            end
            if (!d_req && $urandom_range(0, 99) < 60) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                d_addr = 32'h400 + 32'($urandom_range(0, 7)) * 4;
                d_wdata = $urandom; d_wmask = 4'($urandom_range(0, 15));
            end
            lat = $urandom_range(0, 3);
            if (!i_req && !d_req) begin @(negedge clk); continue; end
            exp_d = pick(i_req, d_req);
            ref_last_d = exp_d;
            ea = exp_d ? d_addr : i_addr;
            ew = d_wdata; em = d_wmask;
            rd = !(exp_d && d_we);
            zm = !rd && (em == '0);
            exp_k = zm ? 2 : 3 + lat;
            run_txn();
            checks++;
            if (obs_side !== exp_d || obs_k !== exp_k || obs_extra !== 1'b0 || obs_unst !== 1'b0) begin
                errors++; $display("FAIL rand_%0d_done: got side=%0d k=%0d extra=%0d unst=%0d expected side=%0d k=%0d",
                                   n, obs_side, obs_k, obs_extra, obs_unst, exp_d, exp_k);
            end
            checks++;
            if (obs_addr !== ea || obs_nld !== int'(rd) || obs_nst !== int'(!rd && !zm)) begin
                errors++; $display("FAIL rand_%0d_strobe: got addr=%h loads=%0d stores=%0d expected %h %0d %0d",
                                   n, obs_addr, obs_nld, obs_nst, ea, rd, !rd && !zm);
            end
            if (rd) begin
                checks++;
                if (obs_rdata !== ref_read(ea)) begin
                    errors++; $display("FAIL rand_%0d_rdata: got %h expected %h", n, obs_rdata, ref_read(ea));
                end
            end else if (!zm) begin
                checks++;
                if (obs_wdata !== ew || obs_mask !== em) begin
                    errors++; $display("FAIL rand_%0d_wfields: got %h/%b expected %h/%b", n, obs_wdata, obs_mask, ew, em);
                end
                ref_mem[ea] = merge(ref_read(ea), ew, em);
            end
        end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_store();
        test_contention();
        test_zero_mask();
        test_reset_in_wait();
        test_min_latency();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
